// File: rtl/fighter_motion_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fighter_motion_ctrl_pkg
// Shared definitions for the per-fighter game logic: jump state encoding,
// horizontal intent encoding, screen constants and default sprite geometry.
// The facing, collision and render blocks import the same defaults so every
// block agrees on sprite width and ground line.
// -----------------------------------------------------------------------------
package fighter_motion_ctrl_pkg;

  localparam int DEF_SCREEN_W = 96;  // screen width in pixels
  localparam int SCREEN_H     = 64;  // screen height in pixels
  localparam int DEF_SPRITE_W = 16;  // sprite width, also min fighter spacing
  localparam int DEF_GROUND_Y = 40;  // sprite_y when standing

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    APEX   = 2'd2,
    FALL   = 2'd3
  } jump_state_t;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } dir_t;

  // Turns relative controls into an absolute direction. Pressing both
  // forward and back cancels out.
  function automatic dir_t resolve_dir(input logic fwd, input logic back,
                                       input logic facing_right);
    case ({fwd, back})
      2'b10:   resolve_dir = facing_right ? DIR_RIGHT : DIR_LEFT;
      2'b01:   resolve_dir = facing_right ? DIR_LEFT : DIR_RIGHT;
      default: resolve_dir = DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fighter_motion_ctrl_if.sv
// -----------------------------------------------------------------------------
// fighter_motion_ctrl_if
// Control/position bundle of one fighter's motion engine.
//   master : input side (synchronizers, facing logic, game state) drives the
//            buttons, facing, opponent x and freeze; reads back positions.
//   slave  : the motion engine itself.
// Signals: btn_fwd, btn_back, btn_jump, facing_right, freeze (1b each),
//          opp_x[6:0]; sprite_x[6:0], sprite_y[6:0], airborne, game_tick.
// -----------------------------------------------------------------------------
interface fighter_motion_ctrl_if;

  logic       btn_fwd;
  logic       btn_back;
  logic       btn_jump;
  logic       facing_right;
  logic [6:0] opp_x;
  logic       freeze;
  logic [6:0] sprite_x;
  logic [6:0] sprite_y;
  logic       airborne;
  logic       game_tick;

  modport master (
    output btn_fwd, btn_back, btn_jump, facing_right, opp_x, freeze,
    input  sprite_x, sprite_y, airborne, game_tick
  );

  modport slave (
    input  btn_fwd, btn_back, btn_jump, facing_right, opp_x, freeze,
    output sprite_x, sprite_y, airborne, game_tick
  );

endinterface

// File: rtl/fighter_motion_ctrl_game_tick_gen.sv
// -----------------------------------------------------------------------------
// game_tick_gen
// Divides the system clock into game ticks. Counts 0..TICK_DIV-1 and emits a
// registered one-cycle pulse on each wrap. Never stalls, so every per-tick
// block sharing it stays in lockstep.
// Ports: clk, rst_n (async active-low), game_tick (out, 1-cycle pulse).
// -----------------------------------------------------------------------------
module game_tick_gen #(
  parameter int TICK_DIV = 1666666
) (
  input  logic clk,
  input  logic rst_n,
  output logic game_tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider; the pulse is registered so it is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      game_tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt       <= '0;
      game_tick <= 1'b1;
    end else begin
      cnt       <= cnt + CW'(1);
      game_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/fighter_motion_ctrl.sv
// -----------------------------------------------------------------------------
// fighter_motion_ctrl
// Per-fighter motion engine. Converts relative controls into absolute sprite
// coordinates once per game tick: 1 px horizontal step with screen clamp and
// body blocking against the opponent, plus a RISE/APEX/FALL jump arc during
// which horizontal motion follows the direction latched at takeoff.
// Ports: clk, rst_n (async active-low), bus (fighter_motion_ctrl_if.slave):
//   in  btn_fwd, btn_back, btn_jump, facing_right, opp_x[6:0], freeze
//   out sprite_x[6:0], sprite_y[6:0], airborne, game_tick (all registered)
// -----------------------------------------------------------------------------
module fighter_motion_ctrl
  import fighter_motion_ctrl_pkg::*;
#(
  parameter int TICK_DIV    = 1666666,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SPRITE_W    = DEF_SPRITE_W,
  parameter int GROUND_Y    = DEF_GROUND_Y,
  parameter int JUMP_HEIGHT = 16,
  parameter int APEX_TICKS  = 4,
  parameter int START_X     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fighter_motion_ctrl_if.slave  bus
);

  localparam logic [7:0] X_MAX     = 8'(SCREEN_W - SPRITE_W);
  localparam logic [6:0] X_MAX7    = 7'(SCREEN_W - SPRITE_W);
  localparam logic [7:0] SPR_W     = 8'(SPRITE_W);
  localparam logic [6:0] Y_GND     = 7'(GROUND_Y);
  localparam logic [6:0] Y_TOP     = 7'(GROUND_Y - JUMP_HEIGHT);
  localparam logic [6:0] X_START   = 7'(START_X);
  localparam logic [7:0] APEX_LAST = 8'(APEX_TICKS - 1);

  logic        tick;
  jump_state_t state;
  logic [6:0]  x_pos;
  logic [6:0]  y_pos;
  logic [7:0]  apex_cnt;
  logic        jump_armed;
  dir_t        drift;
  logic        airborne_q;

  dir_t        ground_dir;
  dir_t        move_dir;
  logic [7:0]  x_ext;
  logic [7:0]  opp_ext;
  logic [7:0]  new_x;
  logic        blocked;
  logic [6:0]  next_x;

  game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .game_tick (tick)
  );

  assign bus.game_tick = tick;
  assign bus.sprite_x  = x_pos;
  assign bus.sprite_y  = y_pos;
  assign bus.airborne  = airborne_q;

  // Candidate x for this tick: step, then body block, then screen clamp.
  // new_x is 8 bits so a step left from 0 shows up as a set MSB.
  always_comb begin
    ground_dir = resolve_dir(bus.btn_fwd, bus.btn_back, bus.facing_right);
    if (state == GROUND) begin
      move_dir = ground_dir;
    end else begin
      move_dir = drift;
    end

    x_ext   = {1'b0, x_pos};
    opp_ext = {1'b0, bus.opp_x};
    case (move_dir)
      DIR_RIGHT: new_x = x_ext + 8'd1;
      DIR_LEFT:  new_x = x_ext - 8'd1;
      default:   new_x = x_ext;
    endcase

    // Only block when approaching from our own side; equal x never blocks so
    // fighters that crossed up can walk apart.
    if ((move_dir == DIR_RIGHT) && (x_ext < opp_ext) && ((new_x + SPR_W) > opp_ext)) begin
      blocked = 1'b1;
    end else if ((move_dir == DIR_LEFT) && (x_ext > opp_ext) && ((opp_ext + SPR_W) > new_x)) begin
      blocked = 1'b1;
    end else begin
      blocked = 1'b0;
    end

    if (blocked) begin
      next_x = x_pos;
    end else if (new_x[7]) begin
      next_x = 7'd0;
    end else if (new_x > X_MAX) begin
      next_x = X_MAX7;
    end else begin
      next_x = new_x[6:0];
    end
  end

  // Jump FSM and position registers; everything holds unless a tick arrives
  // while not frozen, so a frozen jump resumes exactly where it stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= GROUND;
      x_pos      <= X_START;
      y_pos      <= Y_GND;
      apex_cnt   <= 8'd0;
      jump_armed <= 1'b1;
      drift      <= DIR_NONE;
      airborne_q <= 1'b0;
    end else if (tick && !bus.freeze) begin
      x_pos <= next_x;
      case (state)
        GROUND: begin
          // Jump needs a release while grounded before it re-arms.
          if (bus.btn_jump && jump_armed) begin
            state      <= RISE;
            jump_armed <= 1'b0;
            drift      <= ground_dir;
            airborne_q <= 1'b1;
          end else if (!bus.btn_jump) begin
            jump_armed <= 1'b1;
          end
        end
        RISE: begin
          y_pos <= y_pos - 7'd1;
          if (y_pos == (Y_TOP + 7'd1)) begin
            state    <= APEX;
            apex_cnt <= 8'd0;
          end
        end
        APEX: begin
          if (apex_cnt == APEX_LAST) begin
            state <= FALL;
          end else begin
            apex_cnt <= apex_cnt + 8'd1;
          end
        end
        FALL: begin
          y_pos <= y_pos + 7'd1;
          if (y_pos == (Y_GND - 7'd1)) begin
            state      <= GROUND;
            airborne_q <= 1'b0;
          end
        end
        default: begin
          state      <= GROUND;
          y_pos      <= Y_GND;
          airborne_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fighter_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fighter_motion_ctrl
// Self-checking bench for fighter_motion_ctrl with TICK_DIV=4. A per-tick
// reference model tracks x with plain integer arithmetic and derives y from
// the number of ticks spent in the air along the jump trajectory.
// -----------------------------------------------------------------------------
module tb_fighter_motion_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int SCREEN_W    = 96;
  localparam int SPRITE_W    = 16;
  localparam int GROUND_Y    = 40;
  localparam int JUMP_HEIGHT = 16;
  localparam int APEX_TICKS  = 4;
  localparam int START_X     = 8;
  localparam int X_MAX       = SCREEN_W - SPRITE_W;
  localparam int AIR_TICKS   = 2 * JUMP_HEIGHT + APEX_TICKS;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  fighter_motion_ctrl_if bus ();

  fighter_motion_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .SCREEN_W    (SCREEN_W),
    .SPRITE_W    (SPRITE_W),
    .GROUND_Y    (GROUND_Y),
    .JUMP_HEIGHT (JUMP_HEIGHT),
    .APEX_TICKS  (APEX_TICKS),
    .START_X     (START_X)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int m_x;
  int m_y;
  int m_drift;
  int m_air_t;
  bit m_air;
  bit m_armed;

  function automatic int traj_y(input int t);
    if (t <= JUMP_HEIGHT)                   return GROUND_Y - t;
    else if (t <= JUMP_HEIGHT + APEX_TICKS) return GROUND_Y - JUMP_HEIGHT;
    else                                    return GROUND_Y - JUMP_HEIGHT + (t - JUMP_HEIGHT - APEX_TICKS);
  endfunction

  function automatic void model_reset();
    m_x = START_X; m_y = GROUND_Y; m_drift = 0; m_air_t = 0; m_air = 1'b0; m_armed = 1'b1;
  endfunction

  // One game tick of the rules, using the inputs currently on the bus.
  function automatic void model_tick();
    int dir;
    int target;
    int opp;
    if (bus.freeze) return;
    if (!m_air) begin
      if (bus.btn_fwd && !bus.btn_back)      dir = bus.facing_right ? 1 : -1;
      else if (bus.btn_back && !bus.btn_fwd) dir = bus.facing_right ? -1 : 1;
      else                                   dir = 0;
    end else begin
      dir = m_drift;
    end
    target = m_x + dir;
    opp    = int'(bus.opp_x);
    if (!((dir > 0 && m_x < opp && target + SPRITE_W > opp) ||
          (dir < 0 && m_x > opp && opp + SPRITE_W > target))) begin
      m_x = (target < 0) ? 0 : ((target > X_MAX) ? X_MAX : target);
    end
    if (!m_air) begin
      if (bus.btn_jump && m_armed) begin
        m_air = 1'b1; m_air_t = 0; m_armed = 1'b0; m_drift = dir;
      end else if (!bus.btn_jump) begin
        m_armed = 1'b1;
      end
    end else begin
      m_air_t++;
      m_y = traj_y(m_air_t);
      if (m_air_t == AIR_TICKS) m_air = 1'b0;
    end
  endfunction

  // Wait for the next game_tick pulse, advance the model, settle after the edge.
  task automatic tick_step();
    bit seen = 1'b0;
    for (int i = 0; i < 3 * TICK_DIV && !seen; i++) begin
      @(negedge clk);
      if (bus.game_tick === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL tick_timeout: game_tick=%0b after %0d cycles, required a pulse", bus.game_tick, 3 * TICK_DIV);
    end else begin
      model_tick();
    end
    @(posedge clk); #1;
  endtask

  task automatic set_inputs(input bit fwd, input bit back, input bit jump,
                            input bit facing, input int opp, input bit frz);
    bus.btn_fwd = fwd; bus.btn_back = back; bus.btn_jump = jump;
    bus.facing_right = facing; bus.opp_x = 7'(opp); bus.freeze = frz;
  endtask

  task automatic do_reset();
    @(negedge clk); #2; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    set_inputs(1'b0, 1'b0, 1'b0, 1'b1, 60, 1'b0);
    #3 rst_n = 1'b0;
    #20;
    vectors++;
    if (bus.sprite_x !== 7'(START_X) || bus.sprite_y !== 7'(GROUND_Y) || bus.airborne !== 1'b0 || bus.game_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: got x=%0d y=%0d air=%0b tick=%0b, required x=%0d y=%0d air=0 tick=0",
               bus.sprite_x, bus.sprite_y, bus.airborne, bus.game_tick, START_X, GROUND_Y);
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.game_tick !== ((cyc % TICK_DIV) == 0)) begin
        miscompares++;
        $display("FAIL tick_pulse cycle %0d: got %0b, required %0b", cyc, bus.game_tick, (cyc % TICK_DIV) == 0);
      end
    end
    vectors++;
    if (bus.sprite_x !== 7'd8 || bus.sprite_y !== 7'd40 || bus.airborne !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got x=%0d y=%0d air=%0b, required x=8 y=40 air=0", bus.sprite_x, bus.sprite_y, bus.airborne);
    end
  endtask

  task automatic test_walk();
    set_inputs(1'b1, 1'b0, 1'b0, 1'b1, 60, 1'b0);
    for (int t = 0; t < 30; t++) begin
      if (t == 10) bus.facing_right = 1'b0;
      tick_step();
      vectors++;
      if (bus.sprite_x !== 7'(m_x) || bus.sprite_y !== 7'(m_y) || bus.airborne !== m_air) begin
        miscompares++;
        $display("FAIL walk tick %0d: got x=%0d y=%0d air=%0b, required x=%0d y=%0d air=%0b",
                 t, bus.sprite_x, bus.sprite_y, bus.airborne, m_x, m_y, m_air);
      end
      if (t == 9) begin
        vectors++;
        if (bus.sprite_x !== 7'd18) begin
          miscompares++;
          $display("FAIL walk_right_10: got x=%0d, required 18", bus.sprite_x);
        end
      end
    end
    vectors++;
    if (bus.sprite_x !== 7'd0) begin
      miscompares++;
      $display("FAIL walk_clamp_left: got x=%0d, required 0", bus.sprite_x);
    end
  endtask

  task automatic test_block();
    do_reset();
    set_inputs(1'b1, 1'b0, 1'b0, 1'b1, 30, 1'b0);
    for (int t = 0; t < 20; t++) begin
      tick_step();
      vectors++;
      if (bus.sprite_x !== 7'(m_x) || bus.sprite_y !== 7'(m_y)) begin
        miscompares++;
        $display("FAIL block tick %0d: got x=%0d y=%0d, required x=%0d y=%0d", t, bus.sprite_x, bus.sprite_y, m_x, m_y);
      end
    end
    vectors++;
    if (bus.sprite_x !== 7'd14) begin
      miscompares++;
      $display("FAIL block_stop: got x=%0d, required 14", bus.sprite_x);
    end
  endtask

  task automatic test_jump();
    int air_seen = 0;
    do_reset();
    set_inputs(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    for (int t = 0; t < 12; t++) tick_step();
    vectors++;
    if (bus.sprite_x !== 7'd20) begin
      miscompares++;
      $display("FAIL jump_setup: got x=%0d, required 20", bus.sprite_x);
    end
    bus.btn_jump = 1'b1;
    tick_step();
    if (bus.airborne === 1'b1) air_seen++;
    bus.btn_jump = 1'b0; bus.btn_fwd = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick_step();
      if (bus.airborne === 1'b1) air_seen++;
      vectors++;
      if (bus.sprite_x !== 7'(m_x) || bus.sprite_y !== 7'(m_y) || bus.airborne !== m_air) begin
        miscompares++;
        $display("FAIL jump tick %0d: got x=%0d y=%0d air=%0b, required x=%0d y=%0d air=%0b",
                 t, bus.sprite_x, bus.sprite_y, bus.airborne, m_x, m_y, m_air);
      end
    end
    vectors++;
    if (air_seen != AIR_TICKS) begin
      miscompares++;
      $display("FAIL jump_airtime: got %0d airborne ticks, required %0d", air_seen, AIR_TICKS);
    end
  endtask

  task automatic test_hold_jump();
    do_reset();
    set_inputs(1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    for (int t = 0; t < AIR_TICKS + 5; t++) begin
      tick_step();
      vectors++;
      if (bus.sprite_y !== 7'(m_y) || bus.airborne !== m_air) begin
        miscompares++;
        $display("FAIL hold_jump tick %0d: got y=%0d air=%0b, required y=%0d air=%0b", t, bus.sprite_y, bus.airborne, m_y, m_air);
      end
    end
    vectors++;
    if (bus.airborne !== 1'b0) begin
      miscompares++;
      $display("FAIL no_rejump: got air=%0b, required 0", bus.airborne);
    end
    bus.btn_jump = 1'b0; tick_step();
    bus.btn_jump = 1'b1; tick_step();
    vectors++;
    if (bus.airborne !== 1'b1) begin
      miscompares++;
      $display("FAIL rearm_jump: got air=%0b, required 1", bus.airborne);
    end
  endtask

  task automatic test_freeze_reset();
    do_reset();
    set_inputs(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    tick_step();
    bus.btn_jump = 1'b0;
    for (int t = 0; t < 10; t++) tick_step();
    bus.freeze = 1'b1;
    for (int t = 0; t < 10; t++) tick_step();
    vectors++;
    if (bus.sprite_y !== 7'd30 || bus.sprite_x !== 7'(m_x)) begin
      miscompares++;
      $display("FAIL freeze_hold: got x=%0d y=%0d, required x=%0d y=30", bus.sprite_x, bus.sprite_y, m_x);
    end
    bus.freeze = 1'b0;
    for (int t = 0; m_air_t < JUMP_HEIGHT + APEX_TICKS + 5 && t < 60; t++) begin
      tick_step();
      vectors++;
      if (bus.sprite_x !== 7'(m_x) || bus.sprite_y !== 7'(m_y) || bus.airborne !== m_air) begin
        miscompares++;
        $display("FAIL freeze_resume tick %0d: got x=%0d y=%0d air=%0b, required x=%0d y=%0d air=%0b",
                 t, bus.sprite_x, bus.sprite_y, bus.airborne, m_x, m_y, m_air);
      end
    end
    @(negedge clk); #2; rst_n = 1'b0; #1;
    vectors++;
    if (bus.sprite_x !== 7'(START_X) || bus.sprite_y !== 7'(GROUND_Y) || bus.airborne !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_fall: got x=%0d y=%0d air=%0b, required x=%0d y=%0d air=0",
               bus.sprite_x, bus.sprite_y, bus.airborne, START_X, GROUND_Y);
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    set_inputs(1'b0, 1'b0, 1'b0, 1'b1, 60, 1'b0);
    for (int t = 0; t < 300; t++) begin
      bus.btn_fwd      = ($urandom_range(0, 2) != 0);
      bus.btn_back     = ($urandom_range(0, 3) == 0);
      bus.btn_jump     = ($urandom_range(0, 5) == 0);
      bus.facing_right = ($urandom_range(0, 7) != 0) ? bus.facing_right : ~bus.facing_right;
      bus.freeze       = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) bus.opp_x = 7'($urandom_range(0, X_MAX));
      tick_step();
      vectors++;
      if (bus.sprite_x !== 7'(m_x) || bus.sprite_y !== 7'(m_y) || bus.airborne !== m_air) begin
        miscompares++;
        $display("FAIL random tick %0d: got x=%0d y=%0d air=%0b, required x=%0d y=%0d air=%0b",
                 t, bus.sprite_x, bus.sprite_y, bus.airborne, m_x, m_y, m_air);
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_block();
    test_jump();
    test_hold_jump();
    test_freeze_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
